ad_ip_jesd204_tpl_dac_src_ctrl: RTL and testbench

Per-channel data source controller and start sequencer in front of the TPL DAC framer. Selects each converter channel's sample stream from DMA, constant pattern, ramp or zero. Gates transmission through an IDLE/ARMED/RUNNING state machine with optional external-sync start, and detects DMA underflow. Output feeds the framer's dac_data input directly.

---
 rtl/ad_ip_jesd204_tpl_dac_src_pkg.sv | 20 ++
 rtl/ad_ip_jesd204_tpl_dac_src_ctrl_channel.sv | 48 ++++
 rtl/ad_ip_jesd204_tpl_dac_src_ctrl.sv | 121 ++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_src_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_src_pkg.sv
// Shared source codes, sequencer states and sample width for the TPL DAC
// source controller.
package ad_ip_jesd204_tpl_dac_src_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        SRC_ZERO    = 2'd0,
        SRC_DMA     = 2'd1,
        SRC_PATTERN = 2'd2,
        SRC_RAMP    = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2
    } state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl_channel.sv
// One converter channel: source mux, ramp generator and the registered
// output stage that feeds the framer.
module ad_ip_jesd204_tpl_dac_src_ctrl_channel
    import ad_ip_jesd204_tpl_dac_src_pkg::*;
#(
    parameter int DPW = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  src_t                    src,
    input  logic [SAMPLE_W-1:0]     pattern,
    input  logic [DPW*SAMPLE_W-1:0] dma_data,
    input  logic                    dma_valid,
    input  logic                    ramp_clr,
    output logic [DPW*SAMPLE_W-1:0] dac_data
);

    logic [SAMPLE_W-1:0]          ramp;
    logic [DPW-1:0][SAMPLE_W-1:0] beat;

    always_comb begin
        beat = '0;
        for (int s = 0; s < DPW; s++) begin
            case (src)
                // a missing DMA beat is replaced by silence, not stale data
                SRC_DMA:     beat[s] = dma_valid ? dma_data[s*SAMPLE_W +: SAMPLE_W] : '0;
                SRC_PATTERN: beat[s] = pattern;
                SRC_RAMP:    beat[s] = ramp + SAMPLE_W'(s);
                default:     beat[s] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data <= '0;
            ramp     <= '0;
        end else begin
            dac_data <= run ? beat : '0;
            if (ramp_clr)
                ramp <= '0;
            else if (run)
                ramp <= ramp + SAMPLE_W'(DPW);
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl.sv
// Per-channel source selection and start sequencer in front of the TPL DAC
// framer: IDLE/ARMED/RUNNING gating, config shadowing, DMA underflow tracking.
module ad_ip_jesd204_tpl_dac_src_ctrl
    import ad_ip_jesd204_tpl_dac_src_pkg::*;
#(
    parameter int NUM_LANES    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CHANNELS*2-1:0] cfg_src_sel,
    input  logic [15:0]               cfg_pattern,
    input  logic                      cfg_update,
    input  logic                      cfg_sync_mode,
    input  logic                      cfg_arm,
    input  logic                      cfg_stop,
    input  logic                      ext_sync,
    input  logic [NUM_LANES*32-1:0]   dma_data,
    input  logic                      dma_valid,
    output logic                      dma_ready,
    output logic [NUM_LANES*32-1:0]   dac_data,
    output logic [1:0]                status_state,
    output logic                      status_underflow,
    output logic [15:0]               status_underflow_cnt
);

    localparam int DPW = NUM_LANES * 2 / NUM_CHANNELS;
    localparam int CW  = DPW * SAMPLE_W;

    state_t                         state, state_nxt;
    logic                           ext_sync_d;
    logic [NUM_CHANNELS-1:0][1:0]   act_src;
    logic [SAMPLE_W-1:0]            act_pattern;
    logic                           arm_ok, load_cfg, run, any_dma, start_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ext_sync_d <= 1'b0;
        end else begin
            state      <= state_nxt;
            ext_sync_d <= ext_sync;
        end
    end

    always_comb begin
        state_nxt = state;
        arm_ok    = 1'b0;
        if (cfg_stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cfg_arm) begin
                    arm_ok    = 1'b1;
                    state_nxt = cfg_sync_mode ? ST_ARMED : ST_RUNNING;
                end
                // only a fresh rising edge starts; a level already high is ignored
                ST_ARMED: if (ext_sync & ~ext_sync_d) state_nxt = ST_RUNNING;
                default: ;
            endcase
        end
    end

    assign run       = (state == ST_RUNNING);
    assign start_run = (state_nxt == ST_RUNNING) & ~run;
    assign load_cfg  = cfg_update | arm_ok;

    always_comb begin
        any_dma = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            if (act_src[c] == SRC_DMA) any_dma = 1'b1;
    end

    assign dma_ready    = run & any_dma;
    assign status_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_src     <= '0;
            act_pattern <= '0;
        end else if (load_cfg) begin
            act_src     <= cfg_src_sel;
            act_pattern <= cfg_pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || arm_ok) begin
            status_underflow     <= 1'b0;
            status_underflow_cnt <= '0;
        end else if (dma_ready & ~dma_valid) begin
            status_underflow <= 1'b1;
            if (status_underflow_cnt != 16'hFFFF)
                status_underflow_cnt <= status_underflow_cnt + 16'd1;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic ramp_clr;

        // ramp restarts on entering RUNNING or when the channel newly becomes a ramp
        assign ramp_clr = start_run |
                          (load_cfg && (cfg_src_sel[c*2 +: 2] == SRC_RAMP) &&
                           (act_src[c] != SRC_RAMP));

        ad_ip_jesd204_tpl_dac_src_ctrl_channel #(
            .DPW (DPW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .run       (run),
            .src       (src_t'(act_src[c])),
            .pattern   (act_pattern),
            .dma_data  (dma_data[c*CW +: CW]),
            .dma_valid (dma_valid),
            .ramp_clr  (ramp_clr),
            .dac_data  (dac_data[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_src_ctrl.sv
// Scoreboard bench: a behavioural model queues expected outputs each cycle,
// a monitor pops and compares them one step after the clock edge.
module tb_ad_ip_jesd204_tpl_dac_src_ctrl;

    localparam int NL  = 8;
    localparam int NC  = 4;
    localparam int DPW = NL * 2 / NC;
    localparam int W   = NL * 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NC*2-1:0] cfg_src_sel = '0;
    logic [15:0]    cfg_pattern = '0;
    logic           cfg_update = 1'b0, cfg_sync_mode = 1'b0, cfg_arm = 1'b0, cfg_stop = 1'b0;
    logic           ext_sync = 1'b0;
    logic [W-1:0]   dma_data = '0;
    logic           dma_valid = 1'b0;
    logic           dma_ready;
    logic [W-1:0]   dac_data;
    logic [1:0]     status_state;
    logic           status_underflow;
    logic [15:0]    status_underflow_cnt;

    ad_ip_jesd204_tpl_dac_src_ctrl #(.NUM_LANES(NL), .NUM_CHANNELS(NC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_src_sel          (cfg_src_sel),
        .cfg_pattern          (cfg_pattern),
        .cfg_update           (cfg_update),
        .cfg_sync_mode        (cfg_sync_mode),
        .cfg_arm              (cfg_arm),
        .cfg_stop             (cfg_stop),
        .ext_sync             (ext_sync),
        .dma_data             (dma_data),
        .dma_valid            (dma_valid),
        .dma_ready            (dma_ready),
        .dac_data             (dac_data),
        .status_state         (status_state),
        .status_underflow     (status_underflow),
        .status_underflow_cnt (status_underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dac;
        logic [1:0]   st;
        logic         uf;
        logic [15:0]  cnt;
        logic         rdy;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    bit   done = 0;
    bit   rand_dma = 1;

    // reference model state
    int          m_st = 0;
    int          m_src[NC];
    int          m_ramp[NC];
    logic [15:0] m_pat = '0;
    bit          m_uf = 0;
    int          m_cnt = 0;
    bit          m_syncd = 0;

    function automatic bit any_dma_src();
        for (int c = 0; c < NC; c++) if (m_src[c] == 1) return 1;
        return 0;
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   running, rdy, arm_acc;
        int   nxt, v, ns;
        e.dac = '0;
        if (reset) begin
            m_st = 0; m_pat = '0; m_uf = 0; m_cnt = 0; m_syncd = 0;
            for (int c = 0; c < NC; c++) begin m_src[c] = 0; m_ramp[c] = 0; end
        end else begin
            running = (m_st == 2);
            rdy     = running && any_dma_src();
            if (running)
                for (int c = 0; c < NC; c++)
                    for (int s = 0; s < DPW; s++) begin
                        case (m_src[c])
                            1: v = dma_valid ? int'(dma_data[(c*DPW+s)*16 +: 16]) : 0;
                            2: v = int'(m_pat);
                            3: v = (m_ramp[c] + s) % 65536;
                            default: v = 0;
                        endcase
                        e.dac[(c*DPW+s)*16 +: 16] = 16'(v);
                    end
            if (rdy && !dma_valid) begin
                m_uf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            nxt = m_st; arm_acc = 0;
            if (cfg_stop) nxt = 0;
            else if (m_st == 0 && cfg_arm) begin arm_acc = 1; nxt = cfg_sync_mode ? 1 : 2; end
            else if (m_st == 1 && ext_sync && !m_syncd) nxt = 2;
            if (arm_acc) begin m_uf = 0; m_cnt = 0; end
            for (int c = 0; c < NC; c++) begin
                if (running) m_ramp[c] = (m_ramp[c] + DPW) % 65536;
                if (nxt == 2 && m_st != 2) m_ramp[c] = 0;
            end
            if (cfg_update || arm_acc) begin
                for (int c = 0; c < NC; c++) begin
                    ns = int'(cfg_src_sel[2*c +: 2]);
                    if (ns == 3 && m_src[c] != 3) m_ramp[c] = 0;
                    m_src[c] = ns;
                end
                m_pat = cfg_pattern;
            end
            m_st = nxt;
            m_syncd = ext_sync;
        end
        e.st  = 2'(m_st);
        e.uf  = m_uf;
        e.cnt = 16'(m_cnt);
        e.rdy = (m_st == 2) && any_dma_src();
        sb.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (rand_dma)
            for (int i = 0; i < NL; i++) dma_data[i*32 +: 32] = $urandom();
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
    endtask

    task automatic pulse_arm(input bit sync_mode);
        cfg_sync_mode = sync_mode; cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (sb.size() == 0) begin
                chk("sb_empty", W'(0), W'(1));
            end else begin
                e = sb.pop_front();
                chk("dac_data", dac_data, e.dac);
                chk("status_state", W'(status_state), W'(e.st));
                chk("underflow", W'(status_underflow), W'(e.uf));
                chk("underflow_cnt", W'(status_underflow_cnt), W'(e.cnt));
                chk("dma_ready", W'(dma_ready), W'(e.rdy));
            end
        end
    end

    // stimulus
    initial begin
        for (int c = 0; c < NC; c++) begin m_src[c] = 0; m_ramp[c] = 0; end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // all channels pattern 0x1234, immediate start
        cfg_src_sel = 8'hAA; cfg_pattern = 16'h1234;
        pulse_arm(0);
        repeat (5) tick();

        // external sync: level high at arm must not start, fresh edge does
        pulse_stop();
        ext_sync = 1'b1; tick();
        pulse_arm(1);
        repeat (4) tick();
        ext_sync = 1'b0; repeat (2) tick();
        ext_sync = 1'b1; repeat (4) tick();
        ext_sync = 1'b0;

        // ramp on ch0, run long enough to wrap through 0xFFFF
        pulse_stop();
        cfg_src_sel = 8'hAB; cfg_pattern = 16'h0F0F;
        pulse_arm(0);
        repeat (16400) tick();

        // all DMA, three underflow beats, then stop/arm clears the flag
        pulse_stop();
        cfg_src_sel = 8'h55; dma_valid = 1'b1;
        pulse_arm(0);
        repeat (3) tick();
        dma_valid = 1'b0; repeat (3) tick();
        dma_valid = 1'b1; repeat (3) tick();
        pulse_stop();
        pulse_arm(0);
        repeat (2) tick();

        // mixed sources with dma sample k = k
        pulse_stop();
        rand_dma = 0;
        for (int k = 0; k < NL*2; k++) dma_data[k*16 +: 16] = 16'(k);
        cfg_src_sel = 8'hC9; cfg_pattern = 16'hA5A5;
        pulse_arm(0);
        repeat (5) tick();
        cfg_src_sel = 8'h36; repeat (4) tick();
        cfg_update = 1'b1; tick(); cfg_update = 1'b0;
        repeat (4) tick();

        // stop beats arm in IDLE
        pulse_stop();
        cfg_stop = 1'b1; cfg_arm = 1'b1; tick();
        cfg_stop = 1'b0; cfg_arm = 1'b0;
        repeat (3) tick();

        // randomized traffic
        rand_dma = 1;
        for (int i = 0; i < 3000; i++) begin
            cfg_stop      = ($urandom_range(63) == 0);
            cfg_arm       = ($urandom_range(7) == 0);
            cfg_update    = ($urandom_range(15) == 0);
            cfg_sync_mode = $urandom_range(1);
            if ($urandom_range(3) == 0) ext_sync = ~ext_sync;
            cfg_src_sel   = NC*2'($urandom());
            cfg_pattern   = 16'($urandom());
            dma_valid     = ($urandom_range(3) != 0);
            tick();
        end
        cfg_stop = 1'b0; cfg_arm = 1'b0; cfg_update = 1'b0;

        // reset while running
        pulse_stop();
        cfg_src_sel = 8'hE4; dma_valid = 1'b0;
        pulse_arm(0);
        repeat (4) tick();
        reset = 1'b1; tick();
        reset = 1'b0; repeat (3) tick();

        done = 1;
        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
